// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcodes and FSM state encoding shared by the seq_alu slice.
package seq_alu_pkg;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;
  typedef enum logic {S_IDLE, S_MUL} state_t;
endpackage

// File: rtl/seq_alu_mul.sv
// seq_alu_mul: iterative shift-add multiplier, one partial product per cycle.
// done_o is high during the last iteration, with prod_o already showing the final product.
module seq_alu_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [2*WIDTH-1:0] acc_q, mcand_q, acc_d;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0] cnt_q;
  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o = cnt_q == CW'(1);
  assign prod_o = acc_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (start_i) begin
      acc_q <= '0;
      mcand_q <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
      cnt_q <= CW'(WIDTH);
    end else if (cnt_q != '0) begin
      acc_q <= acc_d;
      mcand_q <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q <= cnt_q - CW'(1);
    end
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with valid/ready handshakes and a multi-cycle MUL.
// Define ALU_FLAGS_EN to add registered zero/neg/ovf outputs.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       oper,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef ALU_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg,
  output logic             ovf
`endif
);
  state_t state_q;
  logic out_valid_q, c_out_q, c_out_d, accept, ld_alu, mul_done;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH:0] res;
  logic [2*WIDTH-1:0] prod;
  assign in_ready = (state_q == S_IDLE) & (!out_valid_q | out_ready);
  assign accept = in_valid & in_ready;
  assign ld_alu = accept & (oper != OP_MUL);
  assign out_valid = out_valid_q;
  assign sum = sum_q;
  assign c_out = c_out_q;
  always_comb begin
    res = '0;
    case (oper)
      OP_ADD: res = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
      OP_SUB: res = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, c_in};
      OP_AND: res = {1'b0, a & b};
      OP_OR:  res = {1'b0, a | b};
      OP_XOR: res = {1'b0, a ^ b};
      OP_SHL: res = {a, c_in};
      OP_SHR: res = {a[0], c_in, a[WIDTH-1:1]};
      default: res = '0;
    endcase
  end
  assign sum_d = mul_done ? prod[WIDTH-1:0] : res[WIDTH-1:0];
  assign c_out_d = mul_done ? |prod[2*WIDTH-1:WIDTH] : res[WIDTH];
  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start_i (accept & (oper == OP_MUL)),
    .a_i     (a),
    .b_i     (b),
    .done_o  (mul_done),
    .prod_o  (prod)
  );
`ifdef ALU_FLAGS_EN
  logic zero_q, neg_q, ovf_q, ovf_c;
  logic [WIDTH:0] sgn;
  // Sign-extended arithmetic: overflow when the top two bits disagree.
  assign sgn = (oper == OP_SUB)
    ? {a[WIDTH-1], a} - {b[WIDTH-1], b} - {{WIDTH{1'b0}}, c_in}
    : {a[WIDTH-1], a} + {b[WIDTH-1], b} + {{WIDTH{1'b0}}, c_in};
  assign ovf_c = ((oper == OP_ADD) | (oper == OP_SUB)) & (sgn[WIDTH] ^ sgn[WIDTH-1]);
  assign zero = zero_q;
  assign neg = neg_q;
  assign ovf = ovf_q;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      out_valid_q <= 1'b0;
      sum_q <= '0;
      c_out_q <= 1'b0;
`ifdef ALU_FLAGS_EN
      zero_q <= 1'b0;
      neg_q <= 1'b0;
      ovf_q <= 1'b0;
`endif
    end else begin
      if (accept && oper == OP_MUL) state_q <= S_MUL;
      else if (mul_done) state_q <= S_IDLE;
      if (ld_alu || mul_done) begin
        out_valid_q <= 1'b1;
        sum_q <= sum_d;
        c_out_q <= c_out_d;
`ifdef ALU_FLAGS_EN
        zero_q <= sum_d == '0;
        neg_q <= sum_d[WIDTH-1];
        ovf_q <= ld_alu & ovf_c;
`endif
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and randomized checks of seq_alu against an arithmetic reference model.
// Define ALU_FLAGS_EN to also exercise the flag outputs.
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, c_in, out_valid, out_ready, c_out;
  logic [2:0] oper;
  logic [7:0] a, b, sum;
  int total = 0;
  int passed = 0;
`ifdef ALU_FLAGS_EN
  logic zero, neg, ovf;
`endif

  seq_alu #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .oper      (oper),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out)
`ifdef ALU_FLAGS_EN
    ,
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Returns {c_out, sum} computed with plain integer arithmetic.
  function automatic logic [8:0] model(input logic [2:0] op, input logic [7:0] ra, input logic [7:0] rb, input logic rc);
    int x, y, c, t;
    x = ra;
    y = rb;
    c = rc;
    case (op)
      3'd0: t = x + y + c;
      3'd1: begin
        t = x - y - c;
        return {x < y + c, 8'(t)};
      end
      3'd2: t = x & y;
      3'd3: t = x | y;
      3'd4: t = x ^ y;
      3'd5: t = x * 2 + c;
      3'd6: return {1'(x % 2), 8'(x / 2 + c * 128)};
      default: begin
        t = x * y;
        return {t > 255, 8'(t)};
      end
    endcase
    return 9'(t);
  endfunction

  // Called at a negedge with the block idle; returns at the negedge where the result is visible.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] ra, input logic [7:0] rb,
                        input logic rc, input logic [8:0] expv, input int lat);
    in_valid = 1'b1; oper = op; a = ra; b = rb; c_in = rc;
    #1 chk({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; oper = 3'($urandom); a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
    for (int k = 1; k < lat; k++) begin
      chk({tag, "_early_valid"}, out_valid, 0);
      chk({tag, "_busy_ready"}, in_ready, 0);
      @(negedge clk);
    end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_result"}, {c_out, sum}, expv);
  endtask

  task automatic stream(input int n, input bit sweep);
    logic [8:0] q[$];
    logic [2:0] op;
    logic [7:0] ra, rb;
    logic rc;
    int idx = 0;
    bit prev = 0;
    op = sweep ? 3'd0 : 3'($urandom); rc = sweep ? 1'b0 : 1'($urandom);
    ra = 8'($urandom); rb = 8'($urandom);
    for (int cyc = 0; cyc < 20000 && (idx < n || q.size() > 0); cyc++) begin
      @(negedge clk);
      out_ready = sweep ? 1'b1 : ($urandom_range(3) != 0);
      in_valid = (idx < n) && (sweep || $urandom_range(4) != 0);
      oper = op; a = ra; b = rb; c_in = rc;
      #1;
      if (sweep && prev) chk("b2b_valid", out_valid, 1);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_valid", out_valid, 0);
        else chk(sweep ? "sweep_result" : "rand_result", {c_out, sum}, q.pop_front());
      end
      prev = in_valid && in_ready && op != 3'd7;
      if (in_valid && in_ready) begin
        q.push_back(model(op, ra, rb, rc));
        idx++;
        op = sweep ? 3'(idx) : 3'($urandom);
        rc = sweep ? 1'(idx / 8) : 1'($urandom);
        ra = 8'($urandom); rb = 8'($urandom);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_issued", idx, n);
    chk("stream_drained", q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; oper = 3'd0; a = 8'h00; b = 8'h00; c_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_c_out", c_out, 0);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    run_op("add", 3'd0, 8'h9D, 8'hD7, 1'b0, 9'h174, 1);
    run_op("sub", 3'd1, 8'h9D, 8'hD7, 1'b0, 9'h1C6, 1);
    run_op("and", 3'd2, 8'h9D, 8'hD7, 1'b0, 9'h095, 1);
    run_op("or", 3'd3, 8'h9D, 8'hD7, 1'b0, 9'h0DF, 1);
    run_op("xor", 3'd4, 8'h9D, 8'hD7, 1'b0, 9'h04A, 1);
    run_op("shl", 3'd5, 8'h9D, 8'hD7, 1'b1, 9'h13B, 1);
    run_op("shr", 3'd6, 8'h9D, 8'hD7, 1'b1, 9'h1CE, 1);
    run_op("mul", 3'd7, 8'h9D, 8'hD7, 1'b0, 9'h1DB, 9);
    run_op("add_bp", 3'd0, 8'h9D, 8'hD7, 1'b0, 9'h174, 1);
    out_ready = 1'b0; in_valid = 1'b1; oper = 3'd4; a = 8'h9D; b = 8'hD7; c_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_sum", {c_out, sum}, 9'h174);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_xor_valid", out_valid, 1);
    chk("bp_xor_result", {c_out, sum}, 9'h04A);
    in_valid = 1'b1; oper = 3'd7; a = 8'h9D; b = 8'hD7;
    #1 chk("abort_accept_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk("abort_mid_valid", out_valid, 0);
    chk("abort_mid_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_sum", sum, 0);
    chk("abort_c_out", c_out, 0);
    chk("abort_in_ready", in_ready, 1);
    run_op("post_abort_add", 3'd0, 8'h01, 8'h01, 1'b0, 9'h002, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort_no_result", out_valid, 0);
    end
`ifdef ALU_FLAGS_EN
    run_op("flag_add", 3'd0, 8'h7F, 8'h01, 1'b0, 9'h080, 1);
    chk("flag_ovf", ovf, 1);
    chk("flag_neg", neg, 1);
    chk("flag_zero", zero, 0);
    run_op("flag_and", 3'd2, 8'h9D, 8'h00, 1'b0, 9'h000, 1);
    chk("flag_and_zero", zero, 1);
    chk("flag_and_ovf", ovf, 0);
`endif
    stream(16, 1'b1);
    stream(200, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
